// File: rtl/pong_pkg.sv
// Shared constants for the pong frame painter: screen and object geometry,
// colours, FSM state encoding, rectangle ordering and the clamp helper.
package pong_pkg;

   localparam int SCREEN_W = 320;
   localparam int SCREEN_H = 240;
   localparam int PADDLE_W = 4;
   localparam int PADDLE_H = 32;
   localparam int BALL_SZ  = 4;
   localparam int P1_X     = 8;
   localparam int P2_X     = 308;

   localparam logic [2:0] FG_COLOUR   = 3'b111;
   localparam logic [2:0] BALL_COLOUR = 3'b010;
   localparam logic [2:0] BG_COLOUR   = 3'b000;

   // Clamp windows keep every object one pixel clear of the border
   localparam logic [8:0] POS_LO      = 9'd1;
   localparam logic [8:0] PADDLE_Y_HI = 9'(SCREEN_H - 1 - PADDLE_H);
   localparam logic [8:0] BALL_X_HI   = 9'(SCREEN_W - 1 - BALL_SZ);
   localparam logic [8:0] BALL_Y_HI   = 9'(SCREEN_H - 1 - BALL_SZ);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_SCAN = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [3:0] {
      RECT_TOP,
      RECT_BOTTOM,
      RECT_LEFT,
      RECT_RIGHT,
      RECT_ERASE_P1,
      RECT_ERASE_P2,
      RECT_ERASE_BALL,
      RECT_P1,
      RECT_P2,
      RECT_BALL
   } rect_idx_t;

   function automatic logic [8:0] clamp_u9(input logic [8:0] v,
                                           input logic [8:0] lo,
                                           input logic [8:0] hi);
      if (v < lo)
         return lo;
      else if (v > hi)
         return hi;
      else
         return v;
   endfunction

   // Both the border group and the erase group are followed by the redraw group
   function automatic rect_idx_t next_rect(input rect_idx_t r);
      if (r == RECT_RIGHT || r == RECT_ERASE_BALL)
         return RECT_P1;
      else
         return rect_idx_t'(r + 4'd1);
   endfunction

endpackage

// File: rtl/rect_scan.sv
// Rectangle raster walker: after a one-cycle load it produces one coordinate
// per cycle in row-major order, flagging the final pixel of the rectangle.
module rect_scan
   import pong_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [8:0] x0,
   input  logic [7:0] y0,
   input  logic [8:0] w,
   input  logic [7:0] h,
   output logic [8:0] x,
   output logic [7:0] y,
   output logic       valid,
   output logic       last
);

   logic [8:0] row_start;
   logic [8:0] x_end;
   logic [7:0] y_end;
   logic       row_end;

   assign row_end = (x == x_end);
   assign last    = valid && row_end && (y == y_end);

   // Capture the rectangle on load, then step x fastest and wrap to the next row
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x         <= '0;
         y         <= '0;
         row_start <= '0;
         x_end     <= '0;
         y_end     <= '0;
         valid     <= 1'b0;
      end else if (load) begin
         x         <= x0;
         y         <= y0;
         row_start <= x0;
         x_end     <= x0 + w - 9'd1;
         y_end     <= y0 + h - 8'd1;
         valid     <= 1'b1;
      end else if (valid) begin
         if (row_end) begin
            x <= row_start;
            if (y == y_end)
               valid <= 1'b0;
            else
               y <= y + 8'd1;
         end else begin
            x <= x + 9'd1;
         end
      end
   end

endmodule

// File: rtl/pong_frame_painter.sv
// Pixel-write sequencer for the 320x240 VGA adapter. Each frame tick erases the
// previous paddles and ball (or draws the border on the first frame after
// reset), then draws the paddles and ball at their new clamped positions.
module pong_frame_painter
   import pong_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] paddle1_y,
   input  logic [7:0] paddle2_y,
   input  logic [8:0] ball_x,
   input  logic [7:0] ball_y,
   output logic [8:0] x,
   output logic [7:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic       done
);

   logic [1:0] state;
   rect_idx_t  rect;
   logic       first_frame;

   logic [7:0] new_p1, new_p2, new_by;
   logic [8:0] new_bx;
   logic [7:0] old_p1, old_p2, old_by;
   logic [8:0] old_bx;

   logic [8:0] rect_x0, rect_w;
   logic [7:0] rect_y0, rect_h;
   logic [2:0] rect_colour;

   logic [8:0] scan_x;
   logic [7:0] scan_y;
   logic       scan_valid;
   logic       scan_last;
   logic       pixel_now;

   assign pixel_now = (state == ST_SCAN) && scan_valid;

   // Geometry and colour of the rectangle currently being drawn
   always_comb begin
      rect_x0     = '0;
      rect_y0     = '0;
      rect_w      = 9'd1;
      rect_h      = 8'd1;
      rect_colour = FG_COLOUR;
      case (rect)
         RECT_TOP: begin
            rect_w = 9'(SCREEN_W);
         end
         RECT_BOTTOM: begin
            rect_y0 = 8'(SCREEN_H - 1);
            rect_w  = 9'(SCREEN_W);
         end
         RECT_LEFT: begin
            rect_h = 8'(SCREEN_H);
         end
         RECT_RIGHT: begin
            rect_x0 = 9'(SCREEN_W - 1);
            rect_h  = 8'(SCREEN_H);
         end
         RECT_ERASE_P1: begin
            rect_x0     = 9'(P1_X);
            rect_y0     = old_p1;
            rect_w      = 9'(PADDLE_W);
            rect_h      = 8'(PADDLE_H);
            rect_colour = BG_COLOUR;
         end
         RECT_ERASE_P2: begin
            rect_x0     = 9'(P2_X);
            rect_y0     = old_p2;
            rect_w      = 9'(PADDLE_W);
            rect_h      = 8'(PADDLE_H);
            rect_colour = BG_COLOUR;
         end
         RECT_ERASE_BALL: begin
            rect_x0     = old_bx;
            rect_y0     = old_by;
            rect_w      = 9'(BALL_SZ);
            rect_h      = 8'(BALL_SZ);
            rect_colour = BG_COLOUR;
         end
         RECT_P1: begin
            rect_x0 = 9'(P1_X);
            rect_y0 = new_p1;
            rect_w  = 9'(PADDLE_W);
            rect_h  = 8'(PADDLE_H);
         end
         RECT_P2: begin
            rect_x0 = 9'(P2_X);
            rect_y0 = new_p2;
            rect_w  = 9'(PADDLE_W);
            rect_h  = 8'(PADDLE_H);
         end
         RECT_BALL: begin
            rect_x0     = new_bx;
            rect_y0     = new_by;
            rect_w      = 9'(BALL_SZ);
            rect_h      = 8'(BALL_SZ);
            rect_colour = BALL_COLOUR;
         end
         default: begin
            rect_colour = FG_COLOUR;
         end
      endcase
   end

   rect_scan u_scan (
      .clk   (clk),
      .rst   (rst),
      .load  (state == ST_LOAD),
      .x0    (rect_x0),
      .y0    (rect_y0),
      .w     (rect_w),
      .h     (rect_h),
      .x     (scan_x),
      .y     (scan_y),
      .valid (scan_valid),
      .last  (scan_last)
   );

   // Frame FSM: accept a tick only when fully idle, step through the rectangle
   // list, and retire new positions into the old set at the end of the frame
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         rect        <= RECT_TOP;
         first_frame <= 1'b1;
         new_p1      <= '0;
         new_p2      <= '0;
         new_bx      <= '0;
         new_by      <= '0;
         old_p1      <= '0;
         old_p2      <= '0;
         old_bx      <= '0;
         old_by      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !busy) begin
                  new_p1 <= 8'(clamp_u9({1'b0, paddle1_y}, POS_LO, PADDLE_Y_HI));
                  new_p2 <= 8'(clamp_u9({1'b0, paddle2_y}, POS_LO, PADDLE_Y_HI));
                  new_bx <= clamp_u9(ball_x, POS_LO, BALL_X_HI);
                  new_by <= 8'(clamp_u9({1'b0, ball_y}, POS_LO, BALL_Y_HI));
                  rect   <= first_frame ? RECT_TOP : RECT_ERASE_P1;
                  state  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               state <= ST_SCAN;
            end
            ST_SCAN: begin
               if (scan_last) begin
                  if (rect == RECT_BALL) begin
                     state <= ST_DONE;
                  end else begin
                     rect  <= next_rect(rect);
                     state <= ST_LOAD;
                  end
               end
            end
            ST_DONE: begin
               old_p1      <= new_p1;
               old_p2      <= new_p2;
               old_bx      <= new_bx;
               old_by      <= new_by;
               first_frame <= 1'b0;
               state       <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Registered pixel port; coordinates and colour hold between writes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x      <= '0;
         y      <= '0;
         colour <= '0;
         plot   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         plot <= pixel_now;
         busy <= (state != ST_IDLE);
         done <= (state == ST_DONE);
         if (pixel_now) begin
            x      <= scan_x;
            y      <= scan_y;
            colour <= rect_colour;
         end
      end
   end

endmodule

// File: tb/tb_pong_frame_painter.sv
// Self-checking bench for pong_frame_painter: a list-of-rectangles reference
// model predicts every pixel write of a frame, plus directed clamp, restart
// and mid-frame reset scenarios.
module tb_pong_frame_painter;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] paddle1_y;
   logic [7:0] paddle2_y;
   logic [8:0] ball_x;
   logic [7:0] ball_y;
   logic [8:0] x;
   logic [7:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       busy;
   logic       done;

   int compared_count;
   int mismatched_count;

   // Reference model state
   bit m_first;
   int m_old_p1, m_old_p2, m_old_bx, m_old_by;
   int exp_x[$];
   int exp_y[$];
   int exp_c[$];
   int exp_rects;
   int m_new_p1, m_new_p2, m_new_bx, m_new_by;

   // Observations of the most recent frame
   int obs_px[$];
   int g_p1_min, g_p1_max, g_p2_min, g_p2_max;
   int g_bx_min, g_bx_max, g_by_min, g_by_max;

   pong_frame_painter dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .paddle1_y (paddle1_y),
      .paddle2_y (paddle2_y),
      .ball_x    (ball_x),
      .ball_y    (ball_y),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .plot      (plot),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared_count++;
      if (observed !== expected) begin
         mismatched_count++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, $signed(observed),
                  $signed(expected));
      end
   endtask

   function automatic int clampInt(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   function automatic int packPix(input int px, input int py, input int pc);
      return px * 4096 + py * 8 + pc;
   endfunction

   function automatic int obsAt(input int i);
      if (i >= 0 && i < obs_px.size())
         return obs_px[i];
      return -1;
   endfunction

   task automatic addRect(input int x0, input int y0, input int w, input int h,
                          input int c);
      for (int r = 0; r < h; r++)
         for (int col = 0; col < w; col++) begin
            exp_x.push_back(x0 + col);
            exp_y.push_back(y0 + r);
            exp_c.push_back(c);
         end
      exp_rects++;
   endtask

   task automatic buildExpected(input int p1, input int p2, input int bx, input int by);
      exp_x.delete();
      exp_y.delete();
      exp_c.delete();
      exp_rects = 0;
      m_new_p1 = clampInt(p1, 1, 240 - 1 - 32);
      m_new_p2 = clampInt(p2, 1, 240 - 1 - 32);
      m_new_bx = clampInt(bx, 1, 320 - 1 - 4);
      m_new_by = clampInt(by, 1, 240 - 1 - 4);
      if (m_first) begin
         addRect(0, 0, 320, 1, 7);
         addRect(0, 239, 320, 1, 7);
         addRect(0, 0, 1, 240, 7);
         addRect(319, 0, 1, 240, 7);
      end else begin
         addRect(8, m_old_p1, 4, 32, 0);
         addRect(308, m_old_p2, 4, 32, 0);
         addRect(m_old_bx, m_old_by, 4, 4, 0);
      end
      addRect(8, m_new_p1, 4, 32, 7);
      addRect(308, m_new_p2, 4, 32, 7);
      addRect(m_new_bx, m_new_by, 4, 4, 2);
   endtask

   // Runs one frame and scores it against the model; with hold set, start stays
   // high for the whole frame and must not retrigger a second one
   task automatic applyStimulus(input int p1, input int p2, input int bx,
                                input int by, input bit hold);
      int busy_cycles, plots, dones, first_busy, first_plot, seq_err, oob;
      int border, hold_err, done_plot, done_cycle, last_busy, restarts;
      bit seen_busy, finished;
      logic [8:0] px;
      logic [7:0] py;
      logic [2:0] pc;
      busy_cycles = 0; plots = 0; dones = 0; first_busy = -1; first_plot = -1;
      seq_err = 0; oob = 0; border = 0; hold_err = 0; done_plot = 0;
      done_cycle = -1; last_busy = -2; restarts = 0;
      seen_busy = 1'b0; finished = 1'b0;
      g_p1_min = 999; g_p1_max = -1; g_p2_min = 999; g_p2_max = -1;
      g_bx_min = 999; g_bx_max = -1; g_by_min = 999; g_by_max = -1;
      obs_px.delete();
      buildExpected(p1, p2, bx, by);

      @(negedge clk);
      paddle1_y = 8'(p1);
      paddle2_y = 8'(p2);
      ball_x    = 9'(bx);
      ball_y    = 8'(by);
      start     = 1'b1;
      px = x; py = y; pc = colour;
      @(posedge clk);
      for (int k = 0; k < 4000; k++) begin
         @(negedge clk);
         if (!hold)
            start = 1'b0;
         if (busy) begin
            busy_cycles++;
            if (!seen_busy)
               first_busy = k;
            seen_busy = 1'b1;
            last_busy = k;
         end else if (seen_busy) begin
            finished = 1'b1;
            break;
         end
         if (done) begin
            dones++;
            done_cycle = k;
            if (plot)
               done_plot++;
         end
         if (plot) begin
            if (first_plot < 0)
               first_plot = k;
            if (plots >= exp_x.size() || int'(x) != exp_x[plots] ||
                int'(y) != exp_y[plots] || int'(colour) != exp_c[plots])
               seq_err++;
            obs_px.push_back(packPix(int'(x), int'(y), int'(colour)));
            if (x > 9'd319 || y > 8'd239)
               oob++;
            if (x == 9'd0 || x == 9'd319 || y == 8'd0 || y == 8'd239)
               border++;
            if (colour == 3'd7 && x >= 9'd8 && x <= 9'd11 && y != 8'd0 && y != 8'd239) begin
               if (int'(y) < g_p1_min) g_p1_min = int'(y);
               if (int'(y) > g_p1_max) g_p1_max = int'(y);
            end
            if (colour == 3'd7 && x >= 9'd308 && x <= 9'd311 && y != 8'd0 && y != 8'd239) begin
               if (int'(y) < g_p2_min) g_p2_min = int'(y);
               if (int'(y) > g_p2_max) g_p2_max = int'(y);
            end
            if (colour == 3'd2) begin
               if (int'(x) < g_bx_min) g_bx_min = int'(x);
               if (int'(x) > g_bx_max) g_bx_max = int'(x);
               if (int'(y) < g_by_min) g_by_min = int'(y);
               if (int'(y) > g_by_max) g_by_max = int'(y);
            end
            plots++;
         end else if ({x, y, colour} != {px, py, pc}) begin
            hold_err++;
         end
         px = x; py = y; pc = colour;
      end

      checkOutput("frame_finished", 32'(finished), 32'd1);
      checkOutput("busy_cycles", busy_cycles, exp_rects + exp_x.size() + 1);
      checkOutput("first_busy_cycle", first_busy, 1);
      checkOutput("first_plot_cycle", first_plot, 2);
      checkOutput("plot_count", plots, exp_x.size());
      checkOutput("pixel_seq_errs", seq_err, 0);
      checkOutput("done_pulses", dones, 1);
      checkOutput("done_on_last_busy", done_cycle, last_busy);
      checkOutput("done_with_plot", done_plot, 0);
      checkOutput("out_of_bounds", oob, 0);
      checkOutput("border_pixels", border, m_first ? 1120 : 0);
      checkOutput("hold_errs", hold_err, 0);

      if (hold) begin
         start = 1'b0;
         for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (busy)
               restarts++;
         end
         checkOutput("restart_ignored", restarts, 0);
      end

      if (finished) begin
         m_old_p1 = m_new_p1;
         m_old_p2 = m_new_p2;
         m_old_bx = m_new_bx;
         m_old_by = m_new_by;
         m_first  = 1'b0;
      end
   endtask

   initial begin
      compared_count   = 0;
      mismatched_count = 0;
      m_first  = 1'b1;
      m_old_p1 = 0; m_old_p2 = 0; m_old_bx = 0; m_old_by = 0;
      rst       = 1'b0;
      start     = 1'b0;
      paddle1_y = '0;
      paddle2_y = '0;
      ball_x    = '0;
      ball_y    = '0;

      repeat (3) @(negedge clk);
      checkOutput("reset_outputs", 32'({x, y, colour, plot, busy, done}), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] first frame with border");
      applyStimulus(100, 50, 160, 120, 1'b0);
      checkOutput("f1_first_px", obsAt(0), packPix(0, 0, 7));
      checkOutput("f1_last_px", obsAt(1391), packPix(163, 123, 2));

      $display("[TB] second frame with erase");
      applyStimulus(101, 50, 164, 120, 1'b0);
      checkOutput("f2_erase_first_px", obsAt(0), packPix(8, 100, 0));
      checkOutput("f2_p1_first_px", obsAt(272), packPix(8, 101, 7));

      $display("[TB] clamp frame");
      applyStimulus(0, 255, 0, 239, 1'b0);
      checkOutput("clamp_p1_min", g_p1_min, 1);
      checkOutput("clamp_p1_max", g_p1_max, 32);
      checkOutput("clamp_p2_min", g_p2_min, 207);
      checkOutput("clamp_p2_max", g_p2_max, 238);
      checkOutput("clamp_bx_min", g_bx_min, 1);
      checkOutput("clamp_bx_max", g_bx_max, 4);
      checkOutput("clamp_by_min", g_by_min, 235);
      checkOutput("clamp_by_max", g_by_max, 238);

      $display("[TB] random frames");
      for (int i = 0; i < 5; i++)
         applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 511)), int'($urandom_range(0, 255)), 1'b0);

      $display("[TB] start held high for a whole frame");
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 511)), int'($urandom_range(0, 255)), 1'b1);

      $display("[TB] reset during erase");
      @(negedge clk);
      paddle1_y = 8'd60;
      start     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      checkOutput("mid_erase_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      checkOutput("async_reset_outputs", 32'({x, y, colour, plot, busy, done}), 32'd0);
      @(negedge clk);
      checkOutput("held_reset_outputs", 32'({x, y, colour, plot, busy, done}), 32'd0);
      rst = 1'b1;
      m_first  = 1'b1;
      m_old_p1 = 0; m_old_p2 = 0; m_old_bx = 0; m_old_by = 0;
      @(negedge clk);

      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 511)), int'($urandom_range(0, 255)), 1'b0);
      applyStimulus(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 511)), int'($urandom_range(0, 255)), 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count,
               mismatched_count);
      $finish;
   end

endmodule
